// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment encoder/decoder family.
//  - Segment bit order (bit0=a .. bit6=g), active-high pattern table for hex 0..F.
//  - FSM encodings for the frame reader.
//  - Decode result struct.
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry k is the active-high abcdefg pattern for hex digit k.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic S_COLLECT = 1'b0;
  localparam logic S_HOLD    = 1'b1;

  typedef struct packed {
    logic       hit;
    logic [3:0] nib;
  } dec_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern -> hex nibble lookup.
//  pat     in   7  active-high segments, bit0=a .. bit6=g
//  hit     out  1  pattern matches one of the 16 hex glyphs
//  nibble  out  4  decoded value (0 when hit=0)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic [3:0] nibble
);
  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (pat == SEG_TABLE[k]) begin
        hit    = 1'b1;
        nibble = 4'(k);
      end
    end
  end
endmodule

// File: rtl/seg7_frame_reader.sv
// seg7_frame_reader: samples a multiplexed active-low 7-seg bus, waits for each
// digit to settle, decodes it and assembles NUM_DIGITS digits into a frame
// presented with a valid/ack handshake.
//  clk, rst_n    clock / async active-low reset
//  seg_n[6:0]    segments, active-low, bit0=a .. bit6=g
//  dig_sel       one-hot digit strobe, bit i = digit i
//  hex_out       frame snapshot, digit i at [4i+3:4i]
//  frame_valid   hex_out holds an unacknowledged frame
//  frame_ack     consumer accept (only meaningful while frame_valid=1)
//  digit_valid   digits captured toward the next frame
//  bad_pattern   1-cycle pulse when a stable pattern is not a hex glyph
//  err_cnt[7:0]  saturating bad_pattern count, only with SEG7_ERR_COUNT_EN
module seg7_frame_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic                    frame_valid,
  input  logic                    frame_ack,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    bad_pattern
`ifdef SEG7_ERR_COUNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

  logic [6:0]                  seg_q;
  logic [NUM_DIGITS-1:0]       sel_q;
  logic [CW-1:0]               stab_cnt;
  logic                        state;
  logic [NUM_DIGITS-1:0][3:0]  dig_r;
  logic [NUM_DIGITS-1:0]       dv_nxt;
  logic                        match, capture, cap_hit;
  dec_t                        dec;

  seg7_pattern_decode u_dec (
    .pat    (~seg_n),
    .hit    (dec.hit),
    .nibble (dec.nib)
  );

  // Inputs equal to last cycle's and a single digit strobed.
  assign match   = ({seg_n, dig_sel} == {seg_q, sel_q}) && $onehot(dig_sel);
  // Only the transition into the saturated value captures, so a long
  // stable interval yields exactly one capture.
  assign capture = match && (stab_cnt == CNT_CAP);
  assign cap_hit = capture && dec.hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= 7'h7F;
      sel_q    <= '0;
      stab_cnt <= '0;
    end else begin
      seg_q <= seg_n;
      sel_q <= dig_sel;
      if (!match)                stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // Frame load clears digit_valid, but a same-edge capture keeps its bit.
  always_comb begin
    dv_nxt = digit_valid;
    if (state == S_COLLECT && (&digit_valid)) dv_nxt = '0;
    if (cap_hit) dv_nxt = dv_nxt | dig_sel;
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      dig_r[i] <= 4'h0;
      else if (cap_hit && dig_sel[i])  dig_r[i] <= dec.nib;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out     <= '0;
      frame_valid <= 1'b0;
      digit_valid <= '0;
      bad_pattern <= 1'b0;
      state       <= S_COLLECT;
    end else begin
      bad_pattern <= capture && !dec.hit;
      digit_valid <= dv_nxt;
      case (state)
        S_COLLECT: if (&digit_valid) begin
          hex_out     <= dig_r;
          frame_valid <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: if (frame_ack) begin
          frame_valid <= 1'b0;
          state       <= S_COLLECT;
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err_cnt <= 8'h00;
    else if (frame_ack && frame_valid)    err_cnt <= 8'h00;
    else if (bad_pattern && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
  end
`endif
endmodule

// File: tb/tb_seg7_frame_reader.sv
// Directed testbench for seg7_frame_reader (NUM_DIGITS=4, STABLE_CYCLES=4).
// Define SEG7_ERR_COUNT_EN to also exercise err_cnt.
module tb_seg7_frame_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel;
  logic [15:0] hex_out;
  logic        frame_valid;
  logic        frame_ack;
  logic [3:0]  digit_valid;
  logic        bad_pattern;
`ifdef SEG7_ERR_COUNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int bad_seen = 0;

  seg7_frame_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .hex_out     (hex_out),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .digit_valid (digit_valid),
    .bad_pattern (bad_pattern)
`ifdef SEG7_ERR_COUNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bad_pattern === 1'b1) bad_seen++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int d, input logic [6:0] seg, input int n);
    dig_sel = 4'(1 << d);
    seg_n   = seg;
    step(n);
  endtask

  task automatic idle();
    dig_sel = 4'b0000;
    seg_n   = 7'h7F;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_ack = 1'b0; idle();
    step(2);
    checks++;
    if (hex_out !== 16'h0 || frame_valid !== 1'b0 || digit_valid !== 4'h0 || bad_pattern !== 1'b0) begin
      failures++;
      $display("FAIL reset: hex=%h fv=%b dv=%b bad=%b, want 0", hex_out, frame_valid, digit_valid, bad_pattern);
    end
`ifdef SEG7_ERR_COUNT_EN
    checks++;
    if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err: err_cnt=%h want 00", err_cnt); end
`endif
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic_frame();
    drive(0, ~7'h3F, 6); drive(1, ~7'h06, 6); drive(2, ~7'h5B, 6);
    checks++;
    if (digit_valid !== 4'b0111) begin failures++; $display("FAIL basic_dv012: dv=%b want 0111", digit_valid); end
    drive(3, ~7'h4F, 3);
    checks++;
    if (digit_valid !== 4'b0111) begin failures++; $display("FAIL basic_precap: dv=%b want 0111", digit_valid); end
    step(1);
    checks++;
    if (digit_valid !== 4'hF || frame_valid !== 1'b0) begin
      failures++; $display("FAIL basic_cap: dv=%b fv=%b want 1111/0", digit_valid, frame_valid);
    end
    step(1);
    checks++;
    if (frame_valid !== 1'b1 || hex_out !== 16'h3210 || digit_valid !== 4'h0) begin
      failures++; $display("FAIL basic_frame: fv=%b hex=%h dv=%b want 1/3210/0000", frame_valid, hex_out, digit_valid);
    end
    idle(); ack();
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL basic_ack: fv=%b want 0", frame_valid); end
  endtask

  task automatic test_short_digit();
    drive(0, ~7'h6D, 6); drive(1, ~7'h77, 3); drive(2, ~7'h07, 6); drive(3, ~7'h39, 6);
    checks++;
    if (digit_valid !== 4'b1101 || frame_valid !== 1'b0) begin
      failures++; $display("FAIL short_dv: dv=%b fv=%b want 1101/0", digit_valid, frame_valid);
    end
    drive(1, ~7'h77, 4);
    checks++;
    if (digit_valid !== 4'hF) begin failures++; $display("FAIL short_full: dv=%b want 1111", digit_valid); end
    idle(); step(1);
    checks++;
    if (frame_valid !== 1'b1 || hex_out !== 16'hC7A5) begin
      failures++; $display("FAIL short_frame: fv=%b hex=%h want 1/C7A5", frame_valid, hex_out);
    end
    ack();
  endtask

  task automatic test_bad_pattern();
    int base;
    base = bad_seen;
    drive(0, 7'h00, 6);
    checks++;
    if (digit_valid !== 4'b0001 || bad_seen != base) begin
      failures++; $display("FAIL bad_eight: dv=%b bad=%0d want 0001/0", digit_valid, bad_seen - base);
    end
    drive(1, ~7'h49, 6);
    checks++;
    if (digit_valid !== 4'b0001 || bad_seen != base + 1) begin
      failures++; $display("FAIL bad_49: dv=%b bad=%0d want 0001/1", digit_valid, bad_seen - base);
    end
    drive(2, 7'h7F, 6);
    checks++;
    if (digit_valid !== 4'b0001 || bad_seen != base + 2) begin
      failures++; $display("FAIL bad_blank: dv=%b bad=%0d want 0001/2", digit_valid, bad_seen - base);
    end
    drive(1, ~7'h06, 6); drive(2, ~7'h5B, 6); drive(3, ~7'h4F, 6);
    checks++;
    if (frame_valid !== 1'b1 || hex_out !== 16'h3218) begin
      failures++; $display("FAIL bad_frame: fv=%b hex=%h want 1/3218", frame_valid, hex_out);
    end
    idle(); ack();
  endtask

  task automatic test_back_to_back();
    drive(0, ~7'h39, 6); drive(1, ~7'h5E, 6); drive(2, ~7'h79, 6); drive(3, ~7'h71, 6);
    checks++;
    if (frame_valid !== 1'b1 || hex_out !== 16'hFEDC) begin
      failures++; $display("FAIL b2b_first: fv=%b hex=%h want 1/FEDC", frame_valid, hex_out);
    end
    drive(0, ~7'h4F, 6); drive(1, ~7'h5B, 6); drive(2, ~7'h06, 6); drive(3, ~7'h3F, 6);
    checks++;
    if (frame_valid !== 1'b1 || hex_out !== 16'hFEDC || digit_valid !== 4'hF) begin
      failures++; $display("FAIL b2b_hold: fv=%b hex=%h dv=%b want 1/FEDC/1111", frame_valid, hex_out, digit_valid);
    end
    idle(); ack();
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap: fv=%b want 0", frame_valid); end
    step(1);
    checks++;
    if (frame_valid !== 1'b1 || hex_out !== 16'h0123 || digit_valid !== 4'h0) begin
      failures++; $display("FAIL b2b_second: fv=%b hex=%h dv=%b want 1/0123/0000", frame_valid, hex_out, digit_valid);
    end
    ack();
  endtask

  task automatic test_multihot_and_reset();
    int base;
    base = bad_seen;
    dig_sel = 4'b0110; seg_n = ~7'h3F;
    step(10);
    checks++;
    if (digit_valid !== 4'h0 || bad_seen != base) begin
      failures++; $display("FAIL multihot: dv=%b bad=%0d want 0000/0", digit_valid, bad_seen - base);
    end
    ack();
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL idle_ack: fv=%b want 0", frame_valid); end
    drive(0, ~7'h66, 6); drive(1, ~7'h66, 6); drive(2, ~7'h66, 6); drive(3, ~7'h66, 6);
    drive(0, ~7'h06, 6); drive(1, ~7'h06, 2);
    checks++;
    if (frame_valid !== 1'b1 || hex_out !== 16'h4444 || digit_valid !== 4'b0001) begin
      failures++; $display("FAIL prereset: fv=%b hex=%h dv=%b want 1/4444/0001", frame_valid, hex_out, digit_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hex_out !== 16'h0 || frame_valid !== 1'b0 || digit_valid !== 4'h0 || bad_pattern !== 1'b0) begin
      failures++; $display("FAIL async_reset: hex=%h fv=%b dv=%b bad=%b want 0", hex_out, frame_valid, digit_valid, bad_pattern);
    end
    idle(); step(2);
    rst_n = 1'b1;
    step(1);
  endtask

`ifdef SEG7_ERR_COUNT_EN
  task automatic test_err_count();
    drive(0, ~7'h3F, 6); drive(1, ~7'h3F, 6); drive(2, ~7'h3F, 6); drive(3, ~7'h3F, 6);
    for (int k = 0; k < 10; k++) drive(k % 2, ~7'h49, 4);
    step(2);
    checks++;
    if (err_cnt !== 8'd10) begin failures++; $display("FAIL err_ten: err_cnt=%h want 0A", err_cnt); end
    for (int k = 0; k < 290; k++) drive(k % 2, ~7'h49, 4);
    idle(); step(2);
    checks++;
    if (err_cnt !== 8'hFF || frame_valid !== 1'b1) begin
      failures++; $display("FAIL err_sat: err_cnt=%h fv=%b want FF/1", err_cnt, frame_valid);
    end
    ack();
    checks++;
    if (err_cnt !== 8'h00) begin failures++; $display("FAIL err_clear: err_cnt=%h want 00", err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_short_digit();
    test_bad_pattern();
    test_back_to_back();
    test_multihot_and_reset();
`ifdef SEG7_ERR_COUNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
